// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Each digit gets one refresh slot,
// and each slot opens with an all-anodes-off dead time to avoid ghosting.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] blank_mask,
    output logic [1:0] select,
    output logic [3:0] an,
    output logic       slot_tick
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [1:0]    SEL_LAST  = 2'(NUM_DIGITS - 1);

    generate
        if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES > REFRESH_DIV - 1 ||
            NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_param_check
            $error("seg7_scan_ctrl: parameter out of range");
        end
    endgenerate

    typedef enum logic {PH_BLANK, PH_ON} phase_t;
    localparam phase_t RESET_PH = (BLANK_CYCLES == 0) ? PH_ON : PH_BLANK;

    phase_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      sel_reg, sel_next;
    logic [3:0]      an_reg, an_next;
    logic            tick_reg, wrap;

    always_comb begin
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        state_next = state_reg;
        wrap       = 1'b0;
        if (enable) begin
            wrap = (cnt_reg == CNT_LAST);
            if (wrap) begin
                cnt_next = '0;
                sel_next = (sel_reg == SEL_LAST) ? 2'd0 : sel_reg + 2'd1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
            // Phase follows the count value that will be live after this edge.
            state_next = (BLANK_CYCLES != 0 && cnt_next < BLANK_END) ? PH_BLANK : PH_ON;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            if (gi < NUM_DIGITS) begin : g_used
                assign an_next[gi] = !(enable && state_next == PH_ON &&
                                       sel_next == 2'(gi) && !blank_mask[gi]);
            end else begin : g_unused
                assign an_next[gi] = 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            sel_reg   <= 2'd0;
            an_reg    <= 4'b1111;
            tick_reg  <= 1'b0;
            state_reg <= RESET_PH;
        end else begin
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            an_reg    <= an_next;
            tick_reg  <= wrap;
            state_reg <= state_next;
        end
    end

    assign select    = sel_reg;
    assign an        = an_reg;
    assign slot_tick = tick_reg;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a 2-digit and a 4-digit instance share
// stimulus; a cycle model queues expected outputs which are popped after each edge.
module tb_seg7_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] blank_mask = 4'b0000;
    logic [1:0] sel2, sel4;
    logic [3:0] an2, an4;
    logic       tick2, tick4;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .NUM_DIGITS(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .blank_mask(blank_mask),
        .select(sel2), .an(an2), .slot_tick(tick2));

    seg7_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .NUM_DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .blank_mask(blank_mask),
        .select(sel4), .an(an4), .slot_tick(tick4));

    int          n_checks = 0;
    int          n_fail = 0;
    logic [13:0] sb_q[$];
    int          m_cnt[2] = '{0, 0};
    int          m_sel[2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k, input int nd, output logic [6:0] e);
        logic [3:0] a;
        logic       t;
        a = 4'hF;
        t = 1'b0;
        if (reset) begin
            m_cnt[k] = 0;
            m_sel[k] = 0;
        end else if (enable) begin
            if (m_cnt[k] == 7) begin
                m_cnt[k] = 0;
                m_sel[k] = (m_sel[k] == nd - 1) ? 0 : m_sel[k] + 1;
                t = 1'b1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            if (m_cnt[k] >= 2 && !blank_mask[m_sel[k]]) a[m_sel[k]] = 1'b0;
        end
        e = {2'(m_sel[k]), a, t};
    endtask

    task automatic step();
        logic [6:0]  e0, e1;
        logic [13:0] got;
        model(0, 2, e0);
        model(1, 4, e1);
        sb_q.push_back({e0, e1});
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq("sb_nd2", {9'd0, sel2, an2, tick2}, {9'd0, got[13:7]});
        check_eq("sb_nd4", {9'd0, sel4, an4, tick4}, {9'd0, got[6:0]});
    endtask

    initial begin
        int ticks;
        int s;
        int g;

        // Reset state
        step();
        step();
        check_eq("rst_an", {12'd0, an2}, 16'h000F);
        check_eq("rst_sel", {14'd0, sel2}, 16'd0);
        check_eq("rst_tick", {15'd0, tick2}, 16'd0);

        // Basic scan, both digit counts
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            if (i == 1) begin
                check_eq("t1_e1_an", {12'd0, an2}, 16'h000F);
                check_eq("t1_e1_sel", {14'd0, sel2}, 16'd0);
            end
            if (i == 2) check_eq("t1_e2_an", {12'd0, an2}, 16'h000E);
            if (i == 7) check_eq("t1_e7_an", {12'd0, an2}, 16'h000E);
            if (i == 8) begin
                check_eq("t1_e8_sel", {14'd0, sel2}, 16'd1);
                check_eq("t1_e8_an", {12'd0, an2}, 16'h000F);
                check_eq("t1_e8_tick", {15'd0, tick2}, 16'd1);
            end
            if (i == 9) check_eq("t1_e9_tick", {15'd0, tick2}, 16'd0);
            if (i == 10) begin
                check_eq("t1_e10_an", {12'd0, an2}, 16'h000D);
                check_eq("t2_e10_an4", {12'd0, an4}, 16'h000D);
            end
            if (i == 16) check_eq("t1_e16_sel", {14'd0, sel2}, 16'd0);
            if (i == 18) check_eq("t2_e18_an4", {12'd0, an4}, 16'h000B);
            if (i == 25) check_eq("t2_e25_an4", {12'd0, an4}, 16'h000F);
            if (i == 26) begin
                check_eq("t2_e26_an4", {12'd0, an4}, 16'h0007);
                check_eq("t2_e26_sel4", {14'd0, sel4}, 16'd3);
            end
        end

        // Enable dropped mid-slot at cnt=5, select=0
        for (g = 0; g < 64 && !(m_sel[0] == 0 && m_cnt[0] == 5); g++) step();
        check_eq("t3_reach", {15'd0, (m_sel[0] == 0 && m_cnt[0] == 5)}, 16'd1);
        enable = 1'b0;
        step();
        check_eq("t3_off_an", {12'd0, an2}, 16'h000F);
        check_eq("t3_off_sel", {14'd0, sel2}, 16'd0);
        check_eq("t3_off_tick", {15'd0, tick2}, 16'd0);
        step();
        step();
        enable = 1'b1;
        step();
        check_eq("t3_on_an", {12'd0, an2}, 16'h000E);
        step();
        check_eq("t3_early_tick", {15'd0, tick2}, 16'd0);
        step();
        check_eq("t3_tick", {15'd0, tick2}, 16'd1);

        // Digit 1 masked
        blank_mask = 4'b0010;
        ticks = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (tick2) ticks++;
            if (m_sel[0] == 1) check_eq("t4_masked_an", {12'd0, an2}, 16'h000F);
        end
        check_eq("t4_ticks", ticks[15:0], 16'd3);
        blank_mask = 4'b0000;

        // Reset mid-slot at cnt=5, select=1
        for (g = 0; g < 64 && !(m_sel[0] == 1 && m_cnt[0] == 5); g++) step();
        check_eq("t5_reach", {15'd0, (m_sel[0] == 1 && m_cnt[0] == 5)}, 16'd1);
        reset = 1'b1;
        step();
        check_eq("t5_sel", {14'd0, sel2}, 16'd0);
        check_eq("t5_an", {12'd0, an2}, 16'h000F);
        check_eq("t5_tick", {15'd0, tick2}, 16'd0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) check_eq("t5_no_tick7", {15'd0, tick2}, 16'd0);
            if (i == 8) check_eq("t5_tick8", {15'd0, tick2}, 16'd1);
        end

        // Enable low on the wrap cycle
        for (g = 0; g < 64 && m_cnt[0] != 7; g++) step();
        check_eq("t6_reach", m_cnt[0][15:0], 16'd7);
        s = m_sel[0];
        enable = 1'b0;
        step();
        step();
        check_eq("t6_hold_sel", {14'd0, sel2}, s[15:0]);
        check_eq("t6_hold_tick", {15'd0, tick2}, 16'd0);
        enable = 1'b1;
        step();
        check_eq("t6_tick", {15'd0, tick2}, 16'd1);
        check_eq("t6_sel", {14'd0, sel2}, (s == 1) ? 16'd0 : 16'd1);

        // Random enable / mask / occasional reset
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 99) == 0);
            if (i % 20 == 0) blank_mask = 4'($urandom_range(0, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
